// File: rtl/alu_op_pkg.sv
// ALU operation encoding shared by the execute-stage ALU and the ALU controller.
// Also holds the FSM state type and the shift-kind type used by the iterative shifter.
package alu_op_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_EQ    = 4'b1000,
    OP_PASSB = 4'b1001,
    OP_SLT   = 4'b1100
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_SRL,
    SH_SLL,
    SH_SRA
  } shift_kind_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

  function automatic logic is_legal(logic [3:0] code);
    case (code)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SRL,
      OP_SLL, OP_SRA, OP_EQ, OP_PASSB, OP_SLT: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  function automatic shift_kind_e to_shift_kind(alu_op_e op);
    case (op)
      OP_SLL:  return SH_SLL;
      OP_SRA:  return SH_SRA;
      default: return SH_SRL;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_exec_if.sv
// Operand/result handshake bundle between the hazard unit / ID-EX stage, the ALU and EX/MEM.
interface alu_serial_exec_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             illegal_op;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, illegal_op
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, illegal_op
  );

endinterface

// File: rtl/alu_shift_iter.sv
// Iterative shifter: moves the accumulator by up to SHIFT_STEP bits per cycle until the
// remaining shift amount is exhausted. 'result' is the value the accumulator takes on this edge.
module alu_shift_iter
  import alu_op_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int SHIFT_STEP = 1,
  localparam int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               start,
  input  shift_kind_e        kind,
  input  logic [WIDTH-1:0]   src,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  // One extra bit so SHIFT_STEP == WIDTH is representable.
  localparam logic [SHAMT_W:0] STEP = (SHAMT_W + 1)'(SHIFT_STEP);

  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acc_d;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] step;
  logic               last_step;
  logic               busy_q;
  shift_kind_e        kind_q;

  always_comb begin
    last_step = ({1'b0, rem_q} <= STEP);
    step      = last_step ? rem_q : STEP[SHAMT_W-1:0];
    case (kind_q)
      SH_SLL:  acc_d = acc_q << step;
      SH_SRA:  acc_d = $unsigned($signed(acc_q) >>> step);
      default: acc_d = acc_q >> step;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      acc_q  <= '0;
      rem_q  <= '0;
      kind_q <= SH_SRL;
    end else if (flush) begin
      busy_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      acc_q  <= src;
      rem_q  <= shamt;
      kind_q <= kind;
    end else if (busy_q) begin
      acc_q <= acc_d;
      rem_q <= rem_q - step;
      if (last_step) busy_q <= 1'b0;
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && last_step;
  assign result = acc_d;

endmodule

// File: rtl/alu_serial_exec.sv
// Execute-stage ALU: single-cycle ops complete one cycle after accept, shifts iterate in
// alu_shift_iter. Results sit in an output register with valid/ready back-pressure.
module alu_serial_exec
  import alu_op_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int SHIFT_STEP = 1,
  localparam int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  alu_serial_exec_if.slave bus
);

  alu_state_e         state_q;
  alu_state_e         state_d;
  alu_op_e            op;
  shift_kind_e        shift_kind;
  logic [SHAMT_W-1:0] shamt;
  logic               op_legal;
  logic               op_shift;

  logic               in_ready;
  logic               accept;
  logic               start_shift;
  logic               complete;
  logic               shift_busy;
  logic               shift_done;
  logic [WIDTH-1:0]   shift_res;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   done_res;
  logic               done_illegal;

  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               illegal_q;

  assign op         = alu_op_e'(bus.Operation);
  assign shamt      = bus.SrcB[SHAMT_W-1:0];
  assign op_legal   = is_legal(bus.Operation);
  assign op_shift   = is_shift(op);
  assign shift_kind = to_shift_kind(op);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:                 alu_res = bus.SrcA & bus.SrcB;
      OP_OR:                  alu_res = bus.SrcA | bus.SrcB;
      OP_ADD:                 alu_res = bus.SrcA + bus.SrcB;
      OP_SUB:                 alu_res = bus.SrcA - bus.SrcB;
      OP_XOR:                 alu_res = bus.SrcA ^ bus.SrcB;
      // Shifts only reach the single-cycle path with a zero shift amount.
      OP_SRL, OP_SLL, OP_SRA: alu_res = bus.SrcA;
      OP_EQ:                  alu_res = WIDTH'(bus.SrcA == bus.SrcB);
      OP_PASSB:               alu_res = bus.SrcB;
      OP_SLT:                 alu_res = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
      default:                alu_res = '0;
    endcase
  end

  alu_shift_iter #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .start  (start_shift),
    .kind   (shift_kind),
    .src    (bus.SrcA),
    .shamt  (shamt),
    .busy   (shift_busy),
    .done   (shift_done),
    .result (shift_res)
  );

  // NOTE: every output of this block gets a default first, otherwise a path that skips an assignment infers a latch.
  always_comb begin
    state_d      = state_q;
    start_shift  = 1'b0;
    complete     = 1'b0;
    done_res     = alu_res;
    done_illegal = !op_legal;
    in_ready     = (state_q == ST_IDLE) && !shift_busy && (!out_valid_q || bus.out_ready) && !flush;
    accept       = bus.in_valid && in_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_shift && (shamt != '0)) begin
            start_shift = 1'b1;
            state_d     = ST_SHIFT;
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          complete     = 1'b1;
          done_res     = shift_res;
          done_illegal = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A branch mispredict cancels whatever is in flight, including a completing shift.
    if (flush) begin
      state_d     = ST_IDLE;
      start_shift = 1'b0;
      complete    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      result_q    <= done_res;
      zero_q      <= (done_res == '0);
      illegal_q   <= done_illegal;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.ALUResult  = result_q;
  assign bus.Zero       = zero_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_serial_exec.sv
// Scoreboarded bench for alu_serial_exec: directed corner cases plus randomized ops with
// random back-pressure, checked against a behavioural reference model.
module tb_alu_serial_exec;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    int          lat;
    int          due;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur   = 0;
  bit   prev_valid = 0;
  bit   prev_hs    = 0;
  bit   prev_flush = 0;
  bit   rnd_done   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serial_exec_if #(.WIDTH(WIDTH)) bus ();
  alu_serial_exec_if #(.WIDTH(WIDTH)) bus8 ();

  alu_serial_exec #(.WIDTH(WIDTH), .SHIFT_STEP(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus)
  );

  alu_serial_exec #(.WIDTH(WIDTH), .SHIFT_STEP(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .flush(1'b0), .bus(bus8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                                 input int step);
    exp_t e;
    int   sh;
    sh        = int'(b[4:0]);
    e.illegal = 1'b0;
    e.lat     = 1;
    e.due     = 0;
    case (code)
      4'h0: e.result = a & b;
      4'h1: e.result = a | b;
      4'h2: e.result = a + b;
      4'h3: e.result = a - b;
      4'h4: e.result = a ^ b;
      4'h5: e.result = a >> sh;
      4'h6: e.result = a << sh;
      4'h7: e.result = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'h8: e.result = (a == b) ? 32'd1 : 32'd0;
      4'h9: e.result = b;
      4'hC: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        e.result  = 32'h0;
        e.illegal = 1'b1;
      end
    endcase
    if ((code inside {4'h5, 4'h6, 4'h7}) && sh != 0) e.lat = 1 + (sh + step - 1) / step;
    e.zero = (e.result == 32'h0);
    return e;
  endfunction

  // Called at posedge+1; holds the op until accepted, then returns at posedge+1 after the accept edge.
  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_out, output int waits);
    exp_t e;
    e             = model(code, a, b, 1);
    bus.in_valid  = 1'b1;
    bus.Operation = code;
    bus.SrcA      = a;
    bus.SrcB      = b;
    waits         = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.due = cyc + e.lat;
        if (expect_out) sb.push_back(e);
        break;
      end
      waits++;
      if (waits > 300) begin
        check("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    e              = model(code, a, b, 8);
    bus8.in_valid  = 1'b1;
    bus8.Operation = code;
    bus8.SrcA      = a;
    bus8.SrcB      = b;
    @(negedge clk);
    check("s8_accept", {31'b0, bus8.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus8.out_valid) break;
      lat++;
    end
    check("s8_latency", lat, e.lat);
    check("s8_result", bus8.ALUResult, e.result);
    check("s8_zero", {31'b0, bus8.Zero}, {31'b0, e.zero});
    @(posedge clk); #1;
  endtask

  // Monitor: pops one expectation per new result and re-checks it every cycle it is held.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 0;
      prev_hs    = 0;
      prev_flush = 0;
      have_cur   = 0;
    end else begin
      if (prev_valid && !prev_hs && !prev_flush)
        check("out_valid_held", {31'b0, bus.out_valid}, 32'd1);
      if (bus.out_valid && (!prev_valid || prev_hs)) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", {31'b0, bus.out_valid}, 32'd0);
          have_cur = 0;
        end else begin
          cur      = sb.pop_front();
          have_cur = 1;
          check("latency", cyc, cur.due);
        end
      end
      if (bus.out_valid && have_cur) begin
        check("ALUResult", bus.ALUResult, cur.result);
        check("Zero", {31'b0, bus.Zero}, {31'b0, cur.zero});
        check("illegal_op", {31'b0, bus.illegal_op}, {31'b0, cur.illegal});
      end
      prev_valid = bus.out_valid;
      prev_hs    = bus.out_valid && bus.out_ready;
      prev_flush = flush;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          lowcnt;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hA, 4'hD, 4'hF};
    logic [31:0] corners [4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    bus.in_valid   = 1'b0;
    bus.Operation  = 4'h0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.Operation = 4'h0;
    bus8.SrcA      = '0;
    bus8.SrcB      = '0;
    bus8.out_ready = 1'b1;

    #12;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_ALUResult", bus.ALUResult, 32'd0);
    check("rst_Zero", {31'b0, bus.Zero}, 32'd1);
    check("rst_illegal_op", {31'b0, bus.illegal_op}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Overflow wrap, SUB to zero, EQ, illegal code, signed compare.
    issue(4'h2, 32'h7FFF_FFFF, 32'h1, 1, w);
    issue(4'h3, 32'd5, 32'd5, 1, w);
    issue(4'h8, 32'h1234, 32'h1234, 1, w);
    issue(4'hA, 32'hDEAD_BEEF, 32'h1234_5678, 1, w);
    issue(4'hC, 32'hFFFF_FFFF, 32'h1, 1, w);

    // Longest arithmetic shift keeps the input side stalled for 31 cycles.
    issue(4'h7, 32'h8000_0000, 32'd31, 1, w);
    lowcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      lowcnt++;
    end
    check("sra31_stall_cycles", lowcnt, 32'd31);
    @(posedge clk); #1;

    // Back-pressure: result held for 3 cycles, then a new op is taken as it drains.
    bus.out_ready = 1'b0;
    issue(4'h4, 32'hA5A5_0F0F, 32'hFFFF_0000, 1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    issue(4'h1, 32'h0000_00F0, 32'h0000_0F00, 1, w);
    check("back_to_back_waits", w, 32'd0);

    // Flush mid-SLL: nothing appears, and the op presented during flush is not taken.
    issue(4'h6, 32'h1, 32'd20, 0, w);
    repeat (5) @(posedge clk);
    #1;
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.Operation = 4'h2;
    bus.SrcA      = 32'd3;
    bus.SrcB      = 32'd4;
    @(negedge clk);
    check("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("post_flush_quiet", {31'b0, bus.out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Reset pulse mid-shift.
    issue(4'h6, 32'h1, 32'd20, 0, w);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    check("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("post_reset_quiet", {31'b0, bus.out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Randomized ops with random back-pressure.
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          code = ops[$urandom_range(0, 13)];
          a    = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
          b    = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
          if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
          if ($urandom_range(0, 5) == 0) b = a;
          issue(code, a, b, 1, w);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Eight bits per iteration: exact multiple, partial last step, zero amount.
    issue8(4'h7, 32'h8000_0000, 32'd31);
    issue8(4'h6, 32'h0000_0003, 32'd9);
    issue8(4'h5, 32'hF000_0000, 32'd8);
    issue8(4'h7, 32'h8000_0001, 32'hFFFF_FFE0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
